// File: rtl/integer_multiplier.sv
// integer_multiplier
// Sequential unsigned shift-add multiplier. A start pulse in IDLE loads the
// operands; CALC then runs exactly WIDTH iterations (no early exit) and the
// full 2*WIDTH-bit product is loaded on the final iteration, with a one-cycle
// registered done pulse. The overflow flag marks products wider than WIDTH
// bits, i.e. results that do not fit the display range.
module integer_multiplier #(
  parameter int WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,          // asynchronous, active-low
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 start,
  output logic [2*WIDTH-1:0]   product,
  output logic                 overflow,
  output logic                 busy,
  output logic                 done
);

  // Counter must be able to hold the value WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand_sh;
  logic [WIDTH-1:0]     r_mplier_sh;
  logic [CW-1:0]        r_count;

  logic [2*WIDTH-1:0]   r_product;
  logic                 r_overflow;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_last;
  logic [2*WIDTH-1:0]   w_acc_sum;

  // A start request only counts while idle; starts during CALC/DONE are dropped.
  assign w_accept = (r_state == S_IDLE) && start;

  // The iteration on which the counter steps from 1 to 0 is the final one.
  assign w_last = (r_state == S_CALC) && (r_count == CW'(1));

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier bit is set. The product of two WIDTH-bit values always fits
  // in 2*WIDTH bits, so no carry-out is lost.
  assign w_acc_sum = r_mplier_sh[0] ? (r_acc + r_mcand_sh) : r_acc;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: IDLE -> CALC -> DONE -> IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Working registers: load on accept, then shift/accumulate each CALC cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc       <= '0;
      r_mcand_sh  <= '0;
      r_mplier_sh <= '0;
      r_count     <= '0;
    end else if (w_accept) begin
      r_acc       <= '0;
      r_mcand_sh  <= {{WIDTH{1'b0}}, multiplicand};
      r_mplier_sh <= multiplier;
      r_count     <= CW'(WIDTH);
    end else if (r_state == S_CALC) begin
      r_acc       <= w_acc_sum;
      r_mcand_sh  <= r_mcand_sh << 1;
      r_mplier_sh <= r_mplier_sh >> 1;
      r_count     <= r_count - CW'(1);
    end
  end

  // Result registers: updated only on the final iteration and held through
  // IDLE until the next completion; a new start does not clear them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_product  <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_last) begin
        r_product  <= w_acc_sum;
        r_overflow <= |w_acc_sum[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign product  = r_product;
  assign overflow = r_overflow;
  assign done     = r_done;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_integer_multiplier.sv
// Testbench for integer_multiplier (WIDTH = 10).
// Stimulus pushes hand-computed expectations into a scoreboard queue; an
// independent monitor pops one entry per done pulse and compares product,
// overflow and the start-to-done latency.
module tb_integer_multiplier;

  localparam int W = 10;

  logic             clk;
  logic             reset;
  logic [W-1:0]     multiplicand;
  logic [W-1:0]     multiplier;
  logic             start;
  logic [2*W-1:0]   product;
  logic             overflow;
  logic             busy;
  logic             done;

  typedef struct {
    int unsigned    a;
    int unsigned    b;
    logic [2*W-1:0] p;
    logic           o;
    int             done_cyc;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int txn      = 0;

  integer_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .start        (start),
    .product      (product),
    .overflow     (overflow),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Issue a start at the current negedge; it is accepted at the next posedge.
  // Done must be visible at the negedge WIDTH edges after the accepting edge.
  task automatic issue(input int unsigned a, input int unsigned b,
                       input logic [2*W-1:0] p, input logic o);
    exp_t e;
    e.a = a; e.b = b; e.p = p; e.o = o;
    e.done_cyc = cyc + 1 + W;
    exp_q.push_back(e);
    multiplicand = W'(a);
    multiplier   = W'(b);
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    // Operands are free to change once accepted.
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) return;
    end
    check("wait_done_timeout", 32'd1, 32'd0);
  endtask

  // Monitor: one scoreboard pop per done pulse.
  initial begin : monitor
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done) begin
        check("done_single_pulse", {31'd0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          txn++;
          $display("txn %0d: %0d*%0d -> product=%0d ovf=%0b at cycle %0d (expect %0d ovf=%0b at cycle %0d)",
                   txn, e.a, e.b, product, overflow, cyc, e.p, e.o, e.done_cyc);
          check("product", {12'd0, product}, {12'd0, e.p});
          check("overflow", {31'd0, overflow}, {31'd0, e.o});
          check("latency", cyc, e.done_cyc);
        end
      end
      prev_done = done;
    end
  end

  initial begin : stimulus
    reset        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;

    // Reset state before any clock edge.
    #1;
    check("reset_product", {12'd0, product}, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Basic products and overflow boundary.
    issue(57, 13, 20'd741, 1'b0);      wait_idle();
    issue(1023, 1023, 20'hFF801, 1'b1); wait_idle();
    issue(0, 500, 20'd0, 1'b0);        wait_idle();
    issue(500, 0, 20'd0, 1'b0);        wait_idle();

    // Starts during CALC and during DONE must be ignored.
    issue(57, 13, 20'd741, 1'b0);
    repeat (2) @(negedge clk);
    multiplicand = W'(7);
    multiplier   = W'(7);
    start        = 1'b1;
    repeat (3) @(negedge clk);
    start        = 1'b0;
    wait_done();
    start        = 1'b1;               // present during the DONE cycle
    @(negedge clk);
    start        = 1'b0;
    check("idle_after_ignored_start", {31'd0, busy}, 32'd0);
    issue(7, 7, 20'd49, 1'b0);         wait_idle();

    // Asynchronous reset in the middle of CALC (results currently 49).
    multiplicand = W'(100);
    multiplier   = W'(100);
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    repeat (4) @(negedge clk);
    #3 reset = 1'b0;
    #1;
    check("midreset_product", {12'd0, product}, 32'd0);
    check("midreset_overflow", {31'd0, overflow}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {31'd0, busy}, 32'd0);
    issue(32, 32, 20'd1024, 1'b1);     wait_idle();

    // Back-to-back: second start at the first edge after DONE.
    issue(3, 4, 20'd12, 1'b0);         wait_idle();
    issue(31, 33, 20'd1023, 1'b0);     wait_idle();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
